// File: rtl/collision_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// collision_ctrl_pkg
// Shared types for the collision/damage controller:
//   COORD_W         screen coordinate width (12-bit unsigned)
//   coord_t, box_t  one coordinate and one bounding box (left, right, top, bottom)
//   enemy_state_e   enemy ship life cycle (ALIVE / DEAD)
//   player_state_e  player life cycle (PLAY / INVULN / OVER)
//   cnt_width()     width needed for a frame counter loaded with frames-1
// -----------------------------------------------------------------------------
package collision_ctrl_pkg;

  localparam int COORD_W = 12;

  typedef logic [COORD_W-1:0] coord_t;

  typedef struct packed {
    coord_t x1;
    coord_t x2;
    coord_t y1;
    coord_t y2;
  } box_t;

  typedef enum logic {
    ENEMY_ALIVE = 1'b0,
    ENEMY_DEAD  = 1'b1
  } enemy_state_e;

  typedef enum logic [1:0] {
    PLAYER_PLAY   = 2'd0,
    PLAYER_INVULN = 2'd1,
    PLAYER_OVER   = 2'd2
  } player_state_e;

  // Width of a down-counter that is loaded with (frames-1), never below min_w.
  function automatic int cnt_width(input int frames, input int min_w);
    int w;
    w = $clog2(frames);
    if (w < min_w) w = min_w;
    return w;
  endfunction

endpackage

// File: rtl/collision_ctrl_if.sv
// -----------------------------------------------------------------------------
// collision_ctrl_if
// Bus between the game pipeline and the collision controller.
//   Frame control : i_ani_stb (one clock per frame), i_paused
//   Player        : i_px1/i_px2/i_py1/i_py2, player bullet i_pfiring + i_pb*
//   Enemy         : i_ex1/i_ex2/i_ey1/i_ey2, enemy bullet i_efiring + i_eb*
//   Results       : o_enemy_alive, o_enemy_hit, o_player_hit, o_lives,
//                   o_score, o_player_visible, o_game_over
// Modports: master = game side (drives boxes, reads results),
//           slave  = controller.
// -----------------------------------------------------------------------------
interface collision_ctrl_if #(
  parameter int SCORE_W = 16
);
  import collision_ctrl_pkg::*;

  logic               i_ani_stb;
  logic               i_paused;
  coord_t             i_px1, i_px2, i_py1, i_py2;
  logic               i_pfiring;
  coord_t             i_pbx1, i_pbx2, i_pby1, i_pby2;
  coord_t             i_ex1, i_ex2, i_ey1, i_ey2;
  logic               i_efiring;
  coord_t             i_ebx1, i_ebx2, i_eby1, i_eby2;

  logic               o_enemy_alive;
  logic               o_enemy_hit;
  logic               o_player_hit;
  logic [2:0]         o_lives;
  logic [SCORE_W-1:0] o_score;
  logic               o_player_visible;
  logic               o_game_over;

  modport master (
    output i_ani_stb, i_paused,
    output i_px1, i_px2, i_py1, i_py2, i_pfiring,
    output i_pbx1, i_pbx2, i_pby1, i_pby2,
    output i_ex1, i_ex2, i_ey1, i_ey2, i_efiring,
    output i_ebx1, i_ebx2, i_eby1, i_eby2,
    input  o_enemy_alive, o_enemy_hit, o_player_hit, o_lives,
    input  o_score, o_player_visible, o_game_over
  );

  modport slave (
    input  i_ani_stb, i_paused,
    input  i_px1, i_px2, i_py1, i_py2, i_pfiring,
    input  i_pbx1, i_pbx2, i_pby1, i_pby2,
    input  i_ex1, i_ex2, i_ey1, i_ey2, i_efiring,
    input  i_ebx1, i_ebx2, i_eby1, i_eby2,
    output o_enemy_alive, o_enemy_hit, o_player_hit, o_lives,
    output o_score, o_player_visible, o_game_over
  );

endinterface

// File: rtl/collision_ctrl_box_overlap.sv
// -----------------------------------------------------------------------------
// box_overlap
// Purely combinational axis-aligned box intersection test.
//   a, b : boxes (x1 left, x2 right, y1 top, y2 bottom), 12-bit unsigned
//   hit  : 1 when the interiors intersect; boxes sharing only an edge do not hit
// -----------------------------------------------------------------------------
module box_overlap
  import collision_ctrl_pkg::*;
(
  input  box_t a,
  input  box_t b,
  output logic hit
);

  // Strict compares: touching edges are not an overlap.
  assign hit = (a.x1 < b.x2) && (b.x1 < a.x2) &&
               (a.y1 < b.y2) && (b.y1 < a.y2);

endmodule

// File: rtl/collision_ctrl.sv
// -----------------------------------------------------------------------------
// collision_ctrl
// Frame-rate collision and damage controller. On every active frame
// (i_ani_stb && !i_paused) it decides enemy and player hits from the
// bounding boxes, runs the enemy respawn and player life/invulnerability
// state machines, and keeps lives, score and game-over status.
//   i_clk, i_rst : base clock, asynchronous active-high reset
//   bus (slave)  : boxes/firing flags in, status and hit pulses out
// Parameters: LIVES starting lives (1-7), INV_FRAMES invulnerability length,
//             RESPAWN_FRAMES enemy dead time, SCORE_W score width.
// -----------------------------------------------------------------------------
module collision_ctrl
  import collision_ctrl_pkg::*;
#(
  parameter int LIVES          = 3,
  parameter int INV_FRAMES     = 60,
  parameter int RESPAWN_FRAMES = 120,
  parameter int SCORE_W        = 16
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  collision_ctrl_if.slave       bus
);

  // The blink uses counter bit 3, so the invulnerability counter is at least 4 bits.
  localparam int RESP_W = cnt_width(RESPAWN_FRAMES, 1);
  localparam int INV_W  = cnt_width(INV_FRAMES, 4);

  localparam logic [RESP_W-1:0]  RESP_LOAD  = RESP_W'(RESPAWN_FRAMES - 1);
  localparam logic [INV_W-1:0]   INV_LOAD   = INV_W'(INV_FRAMES - 1);
  localparam logic [2:0]         LIVES_INIT = 3'(LIVES);
  localparam logic [SCORE_W-1:0] SCORE_MAX  = '1;

  // ---------------------------------------------------------------------------
  // Collision terms
  // ---------------------------------------------------------------------------
  box_t player_box, pbullet_box, enemy_box, ebullet_box;
  logic pb_on_enemy, eb_on_player, enemy_on_player;

  assign player_box  = '{x1: bus.i_px1,  x2: bus.i_px2,  y1: bus.i_py1,  y2: bus.i_py2};
  assign pbullet_box = '{x1: bus.i_pbx1, x2: bus.i_pbx2, y1: bus.i_pby1, y2: bus.i_pby2};
  assign enemy_box   = '{x1: bus.i_ex1,  x2: bus.i_ex2,  y1: bus.i_ey1,  y2: bus.i_ey2};
  assign ebullet_box = '{x1: bus.i_ebx1, x2: bus.i_ebx2, y1: bus.i_eby1, y2: bus.i_eby2};

  box_overlap u_pbullet_enemy (.a(pbullet_box), .b(enemy_box),  .hit(pb_on_enemy));
  box_overlap u_ebullet_player(.a(ebullet_box), .b(player_box), .hit(eb_on_player));
  box_overlap u_enemy_player  (.a(enemy_box),   .b(player_box), .hit(enemy_on_player));

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  enemy_state_e       enemy_state;
  logic [RESP_W-1:0]  respawn_cnt;
  logic               enemy_hit_q;
  logic [SCORE_W-1:0] score_q;

  player_state_e      player_state;
  logic [INV_W-1:0]   inv_cnt;
  logic [2:0]         lives_q;
  logic               player_hit_q;
  logic               visible_q;
  logic               game_over_q;

  logic active, enemy_alive, enemy_hit, player_hit;
  logic [INV_W-1:0] inv_dec;

  assign active      = bus.i_ani_stb & ~bus.i_paused;
  assign enemy_alive = (enemy_state == ENEMY_ALIVE);
  assign inv_dec     = inv_cnt - INV_W'(1);

  // Once the game is over the enemy is frozen as well, so no score after OVER.
  assign enemy_hit  = active && (player_state != PLAYER_OVER) &&
                      bus.i_pfiring && enemy_alive && pb_on_enemy;

  // A bullet already in flight still hurts while the enemy is dead; the
  // enemy body only counts while it is alive.
  assign player_hit = active && (player_state == PLAYER_PLAY) &&
                      ((bus.i_efiring && eb_on_player) ||
                       (enemy_alive && enemy_on_player));

  // ---------------------------------------------------------------------------
  // Enemy FSM: ALIVE -> DEAD on hit, back to ALIVE when the respawn count ends.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      enemy_state <= ENEMY_ALIVE;
      respawn_cnt <= '0;
      enemy_hit_q <= 1'b0;
      score_q     <= '0;
    end else begin
      // NOTE: non-blocking assignments here so every register samples the
      // pre-edge values; enemy_hit_q is rewritten every clock, which is what
      // limits the pulse to a single cycle.
      enemy_hit_q <= enemy_hit;
      if (active && player_state != PLAYER_OVER) begin
        unique case (enemy_state)
          ENEMY_ALIVE: begin
            if (enemy_hit) begin
              enemy_state <= ENEMY_DEAD;
              respawn_cnt <= RESP_LOAD;
              if (score_q != SCORE_MAX) score_q <= score_q + SCORE_W'(1);
            end
          end
          ENEMY_DEAD: begin
            if (respawn_cnt == '0) enemy_state <= ENEMY_ALIVE;
            else                   respawn_cnt <= respawn_cnt - RESP_W'(1);
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Player FSM: PLAY / INVULN / OVER with registered lives, blink and game over.
  // ---------------------------------------------------------------------------
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      player_state <= PLAYER_PLAY;
      inv_cnt      <= '0;
      lives_q      <= LIVES_INIT;
      player_hit_q <= 1'b0;
      visible_q    <= 1'b1;
      game_over_q  <= 1'b0;
    end else begin
      player_hit_q <= player_hit;
      if (active) begin
        unique case (player_state)
          PLAYER_PLAY: begin
            if (player_hit) begin
              if (lives_q > 3'd1) begin
                lives_q      <= lives_q - 3'd1;
                player_state <= PLAYER_INVULN;
                inv_cnt      <= INV_LOAD;
                visible_q    <= ~INV_LOAD[3];
              end else begin
                lives_q      <= 3'd0;
                player_state <= PLAYER_OVER;
                visible_q    <= 1'b0;
                game_over_q  <= 1'b1;
              end
            end
          end
          PLAYER_INVULN: begin
            if (inv_cnt == '0) begin
              player_state <= PLAYER_PLAY;
              visible_q    <= 1'b1;
            end else begin
              inv_cnt   <= inv_dec;
              // Sprite follows bit 3 of the count it will show next frame.
              visible_q <= ~inv_dec[3];
            end
          end
          PLAYER_OVER: begin
            // Terminal until reset.
          end
          default: begin
            player_state <= PLAYER_PLAY;
            visible_q    <= 1'b1;
          end
        endcase
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs (all straight from registers)
  // ---------------------------------------------------------------------------
  assign bus.o_enemy_alive    = enemy_alive;
  assign bus.o_enemy_hit      = enemy_hit_q;
  assign bus.o_player_hit     = player_hit_q;
  assign bus.o_lives          = lives_q;
  assign bus.o_score          = score_q;
  assign bus.o_player_visible = visible_q;
  assign bus.o_game_over      = game_over_q;

endmodule

// File: tb/tb_collision_ctrl.sv
// -----------------------------------------------------------------------------
// tb_collision_ctrl
// Scoreboard bench for collision_ctrl. A stimulus process drives boxes and
// frame strobes and, after every clock edge, pushes the outputs a game-rules
// reference model predicts; a monitor process pops and compares them on the
// falling edge (or immediately after an asynchronous reset).
// -----------------------------------------------------------------------------
module tb_collision_ctrl;

  localparam int LIVES   = 3;
  localparam int INV     = 60;
  localparam int RESP    = 120;
  localparam int SW      = 4;
  localparam int SCORE_M = (1 << SW) - 1;

  typedef struct {
    int x1;
    int x2;
    int y1;
    int y2;
  } bbox_t;

  typedef struct {
    bit alive;
    bit ehit;
    bit phit;
    int lives;
    int score;
    bit vis;
    bit over;
  } exp_t;

  logic clk;
  logic rst;

  collision_ctrl_if #(.SCORE_W(SW)) bus ();

  collision_ctrl #(
    .LIVES(LIVES), .INV_FRAMES(INV), .RESPAWN_FRAMES(RESP), .SCORE_W(SW)
  ) dut (
    .i_clk(clk),
    .i_rst(rst),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------------------
  // Checking
  // ---------------------------------------------------------------------------
  int   checks = 0;
  int   errors = 0;
  exp_t sb[$];
  event chk_ev;

  task automatic check(input string name, input int act, input int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d at t=%0t", name, act, expv, $time);
    end
  endtask

  initial begin : monitor
    exp_t e;
    forever begin
      @(negedge clk or chk_ev);
      if (sb.size() > 0) begin
        e = sb.pop_front();
        check("enemy_alive",    int'(bus.o_enemy_alive),    int'(e.alive));
        check("enemy_hit",      int'(bus.o_enemy_hit),      int'(e.ehit));
        check("player_hit",     int'(bus.o_player_hit),     int'(e.phit));
        check("lives",          int'(bus.o_lives),          e.lives);
        check("score",          int'(bus.o_score),          e.score);
        check("player_visible", int'(bus.o_player_visible), int'(e.vis));
        check("game_over",      int'(bus.o_game_over),      int'(e.over));
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Reference model: game rules with plain integers
  // ---------------------------------------------------------------------------
  bit m_alive, m_invuln, m_over, m_ehit, m_phit;
  int m_rleft, m_ileft, m_lives, m_score;

  bbox_t pbox, pbbox, ebox, ebbox;
  bit    pf, ef;

  function automatic bit ovl(input bbox_t a, input bbox_t b);
    return (a.x1 < b.x2) && (b.x1 < a.x2) && (a.y1 < b.y2) && (b.y1 < a.y2);
  endfunction

  task automatic model_reset();
    m_alive = 1; m_invuln = 0; m_over = 0; m_ehit = 0; m_phit = 0;
    m_rleft = 0; m_ileft = 0; m_lives = LIVES; m_score = 0;
  endtask

  task automatic model_frame();
    bit eh, ph;
    if (m_over) return;
    eh = pf && m_alive && ovl(pbbox, ebox);
    ph = !m_invuln && ((ef && ovl(ebbox, pbox)) || (m_alive && ovl(ebox, pbox)));
    m_ehit = eh;
    m_phit = ph;
    if (eh) begin
      m_alive = 0;
      m_rleft = RESP - 1;
      if (m_score < SCORE_M) m_score++;
    end else if (!m_alive) begin
      if (m_rleft == 0) m_alive = 1;
      else              m_rleft--;
    end
    if (ph) begin
      if (m_lives > 1) begin
        m_lives--;
        m_invuln = 1;
        m_ileft  = INV - 1;
      end else begin
        m_lives = 0;
        m_over  = 1;
      end
    end else if (m_invuln) begin
      if (m_ileft == 0) m_invuln = 0;
      else              m_ileft--;
    end
  endtask

  task automatic push_exp();
    exp_t e;
    e.alive = m_alive;
    e.ehit  = m_ehit;
    e.phit  = m_phit;
    e.lives = m_lives;
    e.score = m_score;
    e.vis   = m_over ? 1'b0 : (m_invuln ? (((m_ileft >> 3) & 1) == 0) : 1'b1);
    e.over  = m_over;
    sb.push_back(e);
  endtask

  // ---------------------------------------------------------------------------
  // Stimulus helpers
  // ---------------------------------------------------------------------------
  task automatic drive_bus();
    bus.i_px1  = 12'(pbox.x1);  bus.i_px2  = 12'(pbox.x2);
    bus.i_py1  = 12'(pbox.y1);  bus.i_py2  = 12'(pbox.y2);
    bus.i_pbx1 = 12'(pbbox.x1); bus.i_pbx2 = 12'(pbbox.x2);
    bus.i_pby1 = 12'(pbbox.y1); bus.i_pby2 = 12'(pbbox.y2);
    bus.i_ex1  = 12'(ebox.x1);  bus.i_ex2  = 12'(ebox.x2);
    bus.i_ey1  = 12'(ebox.y1);  bus.i_ey2  = 12'(ebox.y2);
    bus.i_ebx1 = 12'(ebbox.x1); bus.i_ebx2 = 12'(ebbox.x2);
    bus.i_eby1 = 12'(ebbox.y1); bus.i_eby2 = 12'(ebbox.y2);
    bus.i_pfiring = pf;
    bus.i_efiring = ef;
  endtask

  // One clock: inputs settle before the edge, the model follows the edge.
  task automatic tick(input bit stb, input bit paused);
    drive_bus();
    bus.i_ani_stb = stb;
    bus.i_paused  = paused;
    @(posedge clk);
    m_ehit = 0;
    m_phit = 0;
    if (stb && !paused) model_frame();
    push_exp();
    #1;
  endtask

  // One frame = strobe clock plus an idle clock, so pulse width is observed.
  task automatic frame(input bit paused = 1'b0);
    tick(1'b1, paused);
    tick(1'b0, 1'b0);
  endtask

  // Reset asserted between edges; outputs are checked before the next edge.
  task automatic async_reset();
    @(negedge clk);
    #2;
    rst = 1'b1;
    #1;
    model_reset();
    push_exp();
    ->chk_ev;
    #1;
    rst = 1'b0;
  endtask

  function automatic bbox_t rnd_box();
    bbox_t b;
    b.x1 = int'($urandom_range(0, 60));
    b.x2 = b.x1 + int'($urandom_range(0, 20));
    b.y1 = int'($urandom_range(0, 60));
    b.y2 = b.y1 + int'($urandom_range(0, 20));
    return b;
  endfunction

  // ---------------------------------------------------------------------------
  // Test sequence
  // ---------------------------------------------------------------------------
  initial begin : stimulus
    bbox_t far_p, far_e, far_b;
    far_p = '{3000, 3010, 3000, 3010};
    far_e = '{1000, 1010, 1000, 1010};
    far_b = '{2000, 2005, 2000, 2005};

    pbox = far_p; pbbox = far_b; ebox = far_e; ebbox = far_b;
    pf = 0; ef = 0;
    drive_bus();
    bus.i_ani_stb = 1'b0;
    bus.i_paused  = 1'b0;
    rst = 1'b1;
    #3;
    model_reset();
    push_exp();
    ->chk_ev;
    #1;
    rst = 1'b0;

    // Edge touch is not a hit; one pixel of overlap is.
    ebox  = '{110, 170, 50, 60};
    pbbox = '{100, 110, 50, 60};
    pf = 1;
    frame();
    pbbox = '{101, 111, 50, 60};
    frame();
    pf = 0;
    repeat (125) frame();

    // Invulnerability: enemy bullet sits on the player for 70 frames.
    async_reset();
    ebox  = far_e;
    pbox  = '{200, 220, 200, 220};
    ebbox = '{210, 215, 210, 215};
    ef = 1;
    repeat (70) frame();
    ef = 0;
    repeat (60) frame();

    // Last life lost on the same frame the enemy is destroyed.
    ebox  = '{400, 450, 400, 450};
    pbbox = '{410, 420, 410, 420};
    pf = 1; ef = 1;
    frame();
    ebox = '{190, 230, 190, 230};
    repeat (10) frame();
    pf = 0; ef = 0;

    // Pause mid-invulnerability.
    async_reset();
    ebox  = far_e;
    ebbox = '{210, 215, 210, 215};
    ef = 1;
    frame();
    ef = 0;
    repeat (29) frame();
    repeat (200) frame(1'b1);
    repeat (40) frame();

    // Five kills, then reset while the enemy is dead.
    async_reset();
    pbox  = far_p;
    ebox  = '{110, 170, 50, 60};
    pbbox = '{120, 130, 52, 58};
    for (int i = 0; i < 5; i++) begin
      pf = 1;
      frame();
      pf = 0;
      repeat ((i < 4) ? 120 : 10) frame();
    end
    async_reset();

    // Score saturation at 4 bits.
    for (int i = 0; i < 17; i++) begin
      pf = 1;
      frame();
      pf = 0;
      repeat (120) frame();
    end

    // Randomized play.
    async_reset();
    for (int i = 0; i < 3000; i++) begin
      pbox  = rnd_box();
      pbbox = rnd_box();
      ebox  = rnd_box();
      ebbox = rnd_box();
      pf = ($urandom_range(0, 3) != 0);
      ef = ($urandom_range(0, 3) == 0);
      tick($urandom_range(0, 3) != 0, $urandom_range(0, 9) == 0);
      if ((m_over && $urandom_range(0, 7) == 0) || $urandom_range(0, 399) == 0)
        async_reset();
    end

    @(negedge clk);
    #1;
    check("scoreboard_drained", sb.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
